// File: rtl/tr_pulse_pkg.sv
// Shared types and helpers for the multi-channel step-pulse generator.
package tr_pulse_pkg;

  // Per-channel operating state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    AUTO  = 2'd2,
    BURST = 2'd3
  } state_e;

  // Shortest usable period: guarantees a high time of at least one cycle.
  localparam int unsigned MIN_PERIOD = 4;

  // Raise too-short periods to MIN_PERIOD.
  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p < MIN_PERIOD) ? 32'(MIN_PERIOD) : p;
  endfunction

endpackage

// File: rtl/tr_pulse_ch.sv
// One step-pulse channel: mode FSM, period/shadow registers, period and
// burst counters, registered output with live polarity.
module tr_pulse_ch
  import tr_pulse_pkg::*;
#(
  parameter int SIZE       = 16,
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d_v,
  input  logic [SIZE-1:0]  period_in,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             invert,
  input  logic             start,
  input  logic             start_n,
  input  logic             avto,
  input  logic             stop,
  output logic             drv_pulse,
  output logic             busy,
  output logic             done
);

  localparam logic [SIZE-1:0] DEF_P_CLAMPED = SIZE'(clamp_period(32'(DEF_PERIOD)));

  state_e           r_state;
  state_e           w_state_nxt;
  logic [SIZE-1:0]  r_cnt;
  logic [SIZE-1:0]  r_period;
  logic [SIZE-1:0]  r_shadow;
  logic [CNT_W-1:0] r_rem;
  logic             r_step;
  logic             r_out;
  logic             r_done;

  logic             w_p_end;
  logic             w_abort;
  logic             w_enter;
  logic [SIZE-1:0]  w_enter_p;
  logic             w_zero_burst;
  logic             w_burst_end;
  logic             w_step_nxt;

  // Period end only counts while the global enable lets the counter move.
  assign w_p_end = en && (r_cnt == (r_period - SIZE'(1)));

  // Next-state decode: stop always wins, entry only from IDLE while enabled.
  always_comb begin
    w_state_nxt  = r_state;
    w_abort      = 1'b0;
    w_enter      = 1'b0;
    w_enter_p    = r_period;
    w_zero_burst = 1'b0;
    w_burst_end  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!stop && en) begin
          if (avto) begin
            w_state_nxt = AUTO;
            w_enter     = 1'b1;
            w_enter_p   = SIZE'(clamp_period(32'(r_shadow)));
          end else if (start) begin
            w_state_nxt = RUN;
            w_enter     = 1'b1;
            w_enter_p   = DEF_P_CLAMPED;
          end else if (start_n) begin
            if (burst_len == '0) begin
              // Empty burst: report completion without ever leaving IDLE.
              w_zero_burst = 1'b1;
            end else begin
              w_state_nxt = BURST;
              w_enter     = 1'b1;
              w_enter_p   = SIZE'(clamp_period(32'(period_in)));
            end
          end
        end
      end
      RUN: begin
        if (stop) begin
          w_state_nxt = IDLE;
          w_abort     = 1'b1;
        end
      end
      AUTO: begin
        if (stop || !avto) begin
          w_state_nxt = IDLE;
          w_abort     = 1'b1;
        end
      end
      BURST: begin
        if (stop) begin
          w_state_nxt = IDLE;
          w_abort     = 1'b1;
        end else if (w_p_end && (r_rem == CNT_W'(1))) begin
          w_state_nxt = IDLE;
          w_burst_end = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Period counter, active period, shadow period and burst remainder.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_period <= DEF_P_CLAMPED;
      r_shadow <= SIZE'(DEF_PERIOD);
      r_rem    <= '0;
    end else begin
      if (d_v) r_shadow <= period_in;
      if (w_abort || w_burst_end) begin
        r_cnt <= '0;
        r_rem <= '0;
      end else if (w_enter) begin
        r_cnt    <= '0;
        r_period <= w_enter_p;
        r_rem    <= burst_len;
      end else if ((r_state != IDLE) && en) begin
        if (w_p_end) begin
          r_cnt <= '0;
          // A period word arriving at the boundary itself still takes effect now.
          if (r_state == AUTO)
            r_period <= SIZE'(clamp_period(32'(d_v ? period_in : r_shadow)));
          if (r_state == BURST) r_rem <= r_rem - CNT_W'(1);
        end else begin
          r_cnt <= r_cnt + SIZE'(1);
        end
      end
    end
  end

  // Step is cleared immediately on abort and frozen while disabled.
  assign w_step_nxt = w_abort ? 1'b0 :
                      (en ? ((r_state != IDLE) && (r_cnt < (r_period >> 2))) : r_step);

  // Output register: polarity follows invert every cycle; done is a 1-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step <= 1'b0;
      r_out  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_step <= w_step_nxt;
      r_out  <= w_step_nxt ^ invert;
      r_done <= w_burst_end | w_zero_burst;
    end
  end

  assign drv_pulse = r_out;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule

// File: rtl/tr_pulse_multi.sv
// Multi-channel step-pulse generator for the stepper-motor drivers:
// CH independent channels sharing the enable and period-valid strobe.
module tr_pulse_multi
  import tr_pulse_pkg::*;
#(
  parameter int CH         = 2,
  parameter int SIZE       = 16,
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 2000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                drv_en_SM,
  input  logic                d_v,
  input  logic [CH*SIZE-1:0]  period_in,
  input  logic [CH*CNT_W-1:0] burst_len,
  input  logic [CH-1:0]       invert,
  input  logic [CH-1:0]       start,
  input  logic [CH-1:0]       start_n,
  input  logic [CH-1:0]       avto,
  input  logic [CH-1:0]       stop,
  output logic [CH-1:0]       drv_pulse,
  output logic [CH-1:0]       busy,
  output logic [CH-1:0]       done
);

  for (genvar k = 0; k < CH; k++) begin : g_ch
    tr_pulse_ch #(
      .SIZE      (SIZE),
      .CNT_W     (CNT_W),
      .DEF_PERIOD(DEF_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (drv_en_SM),
      .d_v      (d_v),
      .period_in(period_in[k*SIZE +: SIZE]),
      .burst_len(burst_len[k*CNT_W +: CNT_W]),
      .invert   (invert[k]),
      .start    (start[k]),
      .start_n  (start_n[k]),
      .avto     (avto[k]),
      .stop     (stop[k]),
      .drv_pulse(drv_pulse[k]),
      .busy     (busy[k]),
      .done     (done[k])
    );
  end

endmodule

// File: tb/tb_tr_pulse_multi.sv
// Directed bench for tr_pulse_multi (CH=2, SIZE=16, DEF_PERIOD=8).
module tb_tr_pulse_multi;

  logic        clk;
  logic        rst;
  logic        en;
  logic        d_v;
  logic [31:0] period_in;
  logic [31:0] burst_len;
  logic [1:0]  invert;
  logic [1:0]  start;
  logic [1:0]  start_n;
  logic [1:0]  avto;
  logic [1:0]  stop;
  logic [1:0]  drv_pulse;
  logic [1:0]  busy;
  logic [1:0]  done;

  int n_cmp;
  int n_bad;
  logic [63:0] cp0, cp1, cb0, cb1, cd0, cd1;

  tr_pulse_multi #(
    .CH(2), .SIZE(16), .CNT_W(16), .DEF_PERIOD(8)
  ) dut (
    .clk(clk), .rst(rst), .drv_en_SM(en), .d_v(d_v),
    .period_in(period_in), .burst_len(burst_len), .invert(invert),
    .start(start), .start_n(start_n), .avto(avto), .stop(stop),
    .drv_pulse(drv_pulse), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr_cap();
    cp0 = '0; cp1 = '0; cb0 = '0; cb1 = '0; cd0 = '0; cd1 = '0;
  endtask

  task automatic sample(input int k);
    cp0[k] = drv_pulse[0]; cp1[k] = drv_pulse[1];
    cb0[k] = busy[0];      cb1[k] = busy[1];
    cd0[k] = done[0];      cd1[k] = done[1];
  endtask

  task automatic test_reset();
    rst = 1'b1; invert = 2'b11;
    repeat (3) @(negedge clk);
    n_cmp++; if (drv_pulse !== 2'b00) begin n_bad++; $display("FAIL rst_pulse: got %b want 00", drv_pulse); end
    n_cmp++; if (busy !== 2'b00) begin n_bad++; $display("FAIL rst_busy: got %b want 00", busy); end
    n_cmp++; if (done !== 2'b00) begin n_bad++; $display("FAIL rst_done: got %b want 00", done); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (drv_pulse !== 2'b11) begin n_bad++; $display("FAIL idle_inverted: got %b want 11", drv_pulse); end
    invert = 2'b00;
    @(negedge clk);
    n_cmp++; if (drv_pulse !== 2'b00) begin n_bad++; $display("FAIL idle_plain: got %b want 00", drv_pulse); end
  endtask

  task automatic test_run();
    logic [63:0] e;
    clr_cap(); e = '0;
    start = 2'b01; @(negedge clk); start = 2'b00;
    for (int k = 0; k < 24; k++) begin sample(k); @(negedge clk); end
    for (int k = 0; k < 24; k++) if ((k % 8 == 1) || (k % 8 == 2)) e[k] = 1'b1;
    n_cmp++; if (cp0[23:0] !== e[23:0]) begin n_bad++; $display("FAIL run_pulse0: got %h want %h", cp0[23:0], e[23:0]); end
    n_cmp++; if (cp1[23:0] !== 24'h0) begin n_bad++; $display("FAIL run_pulse1: got %h want 0", cp1[23:0]); end
    n_cmp++; if (cb0[23:0] !== 24'hFFFFFF) begin n_bad++; $display("FAIL run_busy0: got %h want ffffff", cb0[23:0]); end
    stop = 2'b01; @(negedge clk); stop = 2'b00; @(negedge clk);
    n_cmp++; if (busy !== 2'b00) begin n_bad++; $display("FAIL run_stop_busy: got %b want 00", busy); end
  endtask

  task automatic test_burst();
    logic [63:0] e;
    clr_cap(); e = '0;
    period_in[31:16] = 16'd12; burst_len[31:16] = 16'd3;
    start_n = 2'b10; @(negedge clk); start_n = 2'b00;
    for (int k = 0; k < 45; k++) begin sample(k); @(negedge clk); end
    for (int k = 0; k < 36; k++) if ((k % 12 >= 1) && (k % 12 <= 3)) e[k] = 1'b1;
    n_cmp++; if (cp1[44:0] !== e[44:0]) begin n_bad++; $display("FAIL burst_pulse1: got %h want %h", cp1[44:0], e[44:0]); end
    e = 64'd1 << 36;
    n_cmp++; if (cd1[44:0] !== e[44:0]) begin n_bad++; $display("FAIL burst_done1: got %h want %h", cd1[44:0], e[44:0]); end
    e = (64'd1 << 36) - 64'd1;
    n_cmp++; if (cb1[44:0] !== e[44:0]) begin n_bad++; $display("FAIL burst_busy1: got %h want %h", cb1[44:0], e[44:0]); end
    n_cmp++; if (cp0[44:0] !== 45'h0) begin n_bad++; $display("FAIL burst_pulse0: got %h want 0", cp0[44:0]); end
  endtask

  task automatic test_auto();
    logic [63:0] e;
    clr_cap(); e = '0;
    period_in[15:0] = 16'd16; d_v = 1'b1; @(negedge clk); d_v = 1'b0;
    avto = 2'b01; @(negedge clk);
    for (int k = 0; k < 45; k++) begin
      sample(k);
      if (k == 6) begin d_v = 1'b1; period_in[15:0] = 16'd20; end
      if (k == 7) d_v = 1'b0;
      if (k == 38) avto = 2'b00;
      @(negedge clk);
    end
    for (int k = 1; k <= 4; k++) e[k] = 1'b1;
    for (int k = 17; k <= 21; k++) e[k] = 1'b1;
    e[37] = 1'b1; e[38] = 1'b1;
    n_cmp++; if (cp0[44:0] !== e[44:0]) begin n_bad++; $display("FAIL auto_pulse0: got %h want %h", cp0[44:0], e[44:0]); end
    e = (64'd1 << 39) - 64'd1;
    n_cmp++; if (cb0[44:0] !== e[44:0]) begin n_bad++; $display("FAIL auto_busy0: got %h want %h", cb0[44:0], e[44:0]); end
  endtask

  task automatic test_invert_stop();
    clr_cap();
    invert = 2'b01; @(negedge clk);
    start = 2'b01; @(negedge clk); start = 2'b00;
    for (int k = 0; k < 8; k++) begin
      sample(k);
      if (k == 1) stop = 2'b01;
      if (k == 2) stop = 2'b00;
      @(negedge clk);
    end
    n_cmp++; if (cp0[7:0] !== 8'b1111_1101) begin n_bad++; $display("FAIL inv_stop_pulse0: got %b want 11111101", cp0[7:0]); end
    n_cmp++; if (cb0[7:0] !== 8'b0000_0011) begin n_bad++; $display("FAIL inv_stop_busy0: got %b want 00000011", cb0[7:0]); end
    clr_cap();
    start = 2'b01; stop = 2'b01; @(negedge clk); start = 2'b00; stop = 2'b00;
    for (int k = 0; k < 6; k++) begin sample(k); @(negedge clk); end
    n_cmp++; if (cb0[5:0] !== 6'h00) begin n_bad++; $display("FAIL start_stop_busy0: got %b want 000000", cb0[5:0]); end
    n_cmp++; if (cp0[5:0] !== 6'h3F) begin n_bad++; $display("FAIL start_stop_pulse0: got %b want 111111", cp0[5:0]); end
    invert = 2'b00; @(negedge clk);
  endtask

  task automatic test_burst_edges();
    clr_cap();
    burst_len[15:0] = 16'd0;
    start_n = 2'b01; @(negedge clk); start_n = 2'b00;
    for (int k = 0; k < 6; k++) begin sample(k); @(negedge clk); end
    n_cmp++; if (cd0[5:0] !== 6'b000001) begin n_bad++; $display("FAIL zero_burst_done0: got %b want 000001", cd0[5:0]); end
    n_cmp++; if (cp0[5:0] !== 6'h00) begin n_bad++; $display("FAIL zero_burst_pulse0: got %b want 000000", cp0[5:0]); end
    n_cmp++; if (cb0[5:0] !== 6'h00) begin n_bad++; $display("FAIL zero_burst_busy0: got %b want 000000", cb0[5:0]); end
    clr_cap();
    period_in[15:0] = 16'd2; burst_len[15:0] = 16'd2;
    start_n = 2'b01; @(negedge clk); start_n = 2'b00;
    for (int k = 0; k < 12; k++) begin sample(k); @(negedge clk); end
    n_cmp++; if (cp0[11:0] !== 12'h022) begin n_bad++; $display("FAIL clamp_pulse0: got %h want 022", cp0[11:0]); end
    n_cmp++; if (cd0[11:0] !== 12'h100) begin n_bad++; $display("FAIL clamp_done0: got %h want 100", cd0[11:0]); end
    n_cmp++; if (cb0[11:0] !== 12'h0FF) begin n_bad++; $display("FAIL clamp_busy0: got %h want 0ff", cb0[11:0]); end
  endtask

  task automatic test_reset_freeze();
    logic [63:0] e;
    clr_cap();
    period_in[31:16] = 16'd12; burst_len[31:16] = 16'd3;
    start_n = 2'b10; @(negedge clk); start_n = 2'b00;
    for (int k = 0; k < 40; k++) begin
      sample(k);
      if (k == 5) rst = 1'b1;
      if (k == 6) rst = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (cp1[39:0] !== 40'hE) begin n_bad++; $display("FAIL rst_abort_pulse1: got %h want e", cp1[39:0]); end
    n_cmp++; if (cb1[39:0] !== 40'h3F) begin n_bad++; $display("FAIL rst_abort_busy1: got %h want 3f", cb1[39:0]); end
    n_cmp++; if (cd1[39:0] !== 40'h0) begin n_bad++; $display("FAIL rst_abort_done1: got %h want 0", cd1[39:0]); end
    clr_cap(); e = '0;
    start = 2'b01; @(negedge clk); start = 2'b00;
    for (int k = 0; k < 26; k++) begin
      sample(k);
      if (k == 4) en = 1'b0;
      if (k == 9) en = 1'b1;
      @(negedge clk);
    end
    e[1] = 1'b1; e[2] = 1'b1; e[14] = 1'b1; e[15] = 1'b1; e[22] = 1'b1; e[23] = 1'b1;
    n_cmp++; if (cp0[25:0] !== e[25:0]) begin n_bad++; $display("FAIL freeze_pulse0: got %h want %h", cp0[25:0], e[25:0]); end
    n_cmp++; if (cb0[25:0] !== 26'h3FFFFFF) begin n_bad++; $display("FAIL freeze_busy0: got %h want 3ffffff", cb0[25:0]); end
    en = 1'b0; stop = 2'b01; @(negedge clk); stop = 2'b00; en = 1'b1;
    n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL stop_while_frozen_busy0: got %b want 0", busy[0]); end
    n_cmp++; if (drv_pulse[0] !== 1'b0) begin n_bad++; $display("FAIL stop_while_frozen_pulse0: got %b want 0", drv_pulse[0]); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; en = 1'b1; d_v = 1'b0;
    period_in = '0; burst_len = '0;
    invert = '0; start = '0; start_n = '0; avto = '0; stop = '0;
    test_reset();
    test_run();
    test_burst();
    test_auto();
    test_invert_stop();
    test_burst_edges();
    test_reset_freeze();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
